ball_motion_renderer: RTL and testbench
=======================================

# ball_motion_renderer

Frame-rate object engine for the 25 MHz VGA pixel domain. Holds the position and velocity of one square ball, updates it once per frame from debounced direction buttons in manual or auto-bounce mode, and produces the registered per-pixel colour fed to `vga_core.color_in`. It sits between the button debouncers and `vga_core`, and extends a fixed-size, manual-only cursor with parametrised geometry, velocity, wall bounce and exact-size rendering.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible width in pixels
- `V_ACTIVE`, 480, visible height in pixels
- `BALL_SIZE`, 10, ball edge in pixels; must be ≥1 and less than both `H_ACTIVE` and `V_ACTIVE`
- `STEP`, 2, manual-mode pixels per frame
- `MAX_SPEED`, 7, bounce-mode speed limit per axis, in px/frame
- `BALL_COLOR`, 12'hFFF, ball colour as {R,G,B} 4 bits each
- `BG_COLOR`, 12'h00F, background colour

Ports:
- `clk` in 1: pixel clock, 25 MHz
- `rst` in 1: reset; one clock, asynchronous and active-high
- `frame_tick` in 1: one-cycle pulse, once per frame
- `up`, `down`, `left`, `right`, `center` in 1 each: debounced levels
- `mode` in 1: 0 = manual, 1 = bounce
- `x_coord`, `y_coord` in 16 each: current pixel from `vga_core`
- `color_o` out 12: pixel colour
- `ball_x`, `ball_y` out 16 each: top-left corner of the ball
- `bounce_o` out 1: one-cycle pulse on any wall hit

## Operation
- Constants:
  - `XMAX = H_ACTIVE-BALL_SIZE`, `YMAX = V_ACTIVE-BALL_SIZE`.
  - Centre is `(XMAX/2, YMAX/2)`, using floor division.
- FSM states: `IDLE`, `CALC`, `COMMIT`.
  - `IDLE`: goes to `CALC` on `frame_tick`.
  - `CALC`: computes next position and velocity into shadow registers, then goes to `COMMIT`.
  - `COMMIT`: loads `ball_x`, `ball_y` and velocity, drives `bounce_o`, then returns to `IDLE`.
- `frame_tick` is ignored outside `IDLE`.
- `mode` and the buttons are sampled in `CALC` only.
- `center` has priority in both modes. It puts the ball at the centre, and in bounce mode it also sets velocity to (0,0).
- Manual mode, per axis:
  - Move `STEP` in the pressed direction.
  - If both opposing buttons are pressed, that axis does not move.
  - Result is clamped to `[0, XMAX]` or `[0, YMAX]`.
  - `bounce_o` stays 0.
- Bounce mode, per axis:
  - Velocity is signed, 5 bits.
  - A pressed direction button adds ±1 to velocity, saturating at ±`MAX_SPEED`. If both opposing buttons are pressed, velocity is unchanged.
  - The new position is `pos + v_new`, computed in 17-bit signed arithmetic.
  - If the result is below 0, position becomes 0 and velocity becomes `-v_new`.
  - If the result is above the max, position becomes max and velocity becomes `-v_new`.
  - Either case counts as a bounce.
- Rendering:
  - The ball covers `ball_x ≤ x_coord ≤ ball_x+BALL_SIZE-1` and the matching y range, exactly `BALL_SIZE`² pixels.
  - Inside the ball `color_o` is `BALL_COLOR`, otherwise `BG_COLOR`.
  - Coordinates outside the active area are not special-cased; `vga_core` blanks them.

## Timing
- Reset values:
  - `ball_x/ball_y` at the centre.
  - Velocity (+1,+1).
  - FSM in `IDLE`.
  - `color_o = BG_COLOR`, `bounce_o = 0`.
- `color_o` is registered with 1-cycle latency from `x_coord/y_coord`.
- Position latency:
  - `ball_x/ball_y` change exactly 2 cycles after the `frame_tick` cycle, in the `COMMIT` cycle.
  - They are stable at every other time.
- `bounce_o` is high for exactly the `COMMIT` cycle, and only if at least one axis bounced.
- Frame ticks:
  - A tick in `CALC` or `COMMIT` is dropped.
  - Ticks must be spaced ≥3 cycles apart.
- Reset asserted mid-update aborts immediately to the reset values; no partial commit.
- A `mode` change takes effect at the next `CALC`. Velocity is retained across mode switches.

## Structure
- Package `vga_pkg`: `H_ACTIVE`, `V_ACTIVE`, colour width (12), coordinate width (16), FSM state encodings.
- Sub-module `axis_motion`, instantiated once for x and once for y:
  - Inputs: position, velocity, inc/dec buttons, mode, max.
  - Outputs: next position, next velocity, hit.
  - Purely combinational.
- The FSM and render logic stay in the top module.

## Test plan
Default parameters throughout; centre is (315,235).
- **Reset:** assert `rst` → `ball=(315,235)`, `color_o=12'h00F`, `bounce_o=0`.
- **Manual move and clamp:** `mode=0`, `right` held for 5 ticks → `ball_x=325`. From `ball_x=629`, one tick with `right` → 630; a further tick → still 630, `bounce_o` never 1.
- **Render boundary:** ball at (315,235).
  - Pixels (315,235) and (324,244) → `12'hFFF` one cycle later.
  - Pixels (325,235) and (314,240) → `12'h00F`.
- **Bounce:** `mode=1`, `ball_x=628`, `vx=+3`, no buttons, tick → `ball_x=630`, `vx=-3`, `bounce_o` high for one cycle 2 cycles after the tick.
- **Velocity saturation:** `mode=1`, `vx=+1`, `right` held for 10 ticks → `vx=+7`. Then `center` for one tick → `ball=(315,235)`, `v=(0,0)`.
- **Mid-update reset and dropped tick:**
  - `rst` pulsed in the `CALC` cycle → reset values, FSM `IDLE`, no `bounce_o`.
  - A second `frame_tick` in the `CALC` cycle → only one update.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and the ball engine's frame-update state encoding.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COLOR_W  = 12;
  localparam int COORD_W  = 16;
  localparam int VEL_W    = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;
endpackage

// File: rtl/axis_motion.sv
// Combinational next-position/next-velocity for one axis of the ball,
// covering both manual stepping with clamp and signed-velocity wall bounce.
module axis_motion import vga_pkg::*; #(
  parameter int STEP      = 2,
  parameter int MAX_SPEED = 7
) (
  input  logic [COORD_W-1:0]      pos,
  input  logic signed [VEL_W-1:0] vel,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    mode,
  input  logic [COORD_W-1:0]      pos_max,
  output logic [COORD_W-1:0]      next_pos,
  output logic signed [VEL_W-1:0] next_vel,
  output logic                    hit
);
  localparam logic signed [VEL_W-1:0] VMAX   = VEL_W'(MAX_SPEED);
  localparam logic [COORD_W:0]        STEP_W = (COORD_W+1)'(STEP);

  logic signed [VEL_W-1:0] v_new;
  logic signed [COORD_W:0] sum;
  logic [COORD_W:0]        fwd;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    v_new = vel;
    if (inc && !dec && vel < VMAX)
      v_new = vel + VEL_W'(1);
    else if (dec && !inc && vel > -VMAX)
      v_new = vel - VEL_W'(1);

    // One guard bit so a step past either wall is still visible as a sign/overflow.
    sum = $signed({1'b0, pos}) + $signed({{(COORD_W+1-VEL_W){v_new[VEL_W-1]}}, v_new});
    fwd = {1'b0, pos} + STEP_W;

    next_pos = pos;
    next_vel = vel;
    hit      = 1'b0;

    if (!mode) begin
      if (inc && !dec)
        next_pos = (fwd > {1'b0, pos_max}) ? pos_max : fwd[COORD_W-1:0];
      else if (dec && !inc)
        next_pos = ({1'b0, pos} < STEP_W) ? '0 : pos - STEP_W[COORD_W-1:0];
    end else begin
      next_vel = v_new;
      if (sum < 0) begin
        next_pos = '0;
        next_vel = -v_new;
        hit      = 1'b1;
      end else if (sum > $signed({1'b0, pos_max})) begin
        next_pos = pos_max;
        next_vel = -v_new;
        hit      = 1'b1;
      end else begin
        next_pos = sum[COORD_W-1:0];
      end
    end
  end
endmodule

// File: rtl/ball_motion_renderer.sv
// Once-per-frame ball position/velocity update (IDLE -> CALC -> COMMIT) and the
// registered per-pixel colour for vga_core.
module ball_motion_renderer import vga_pkg::*; #(
  parameter int                 H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int                 V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int                 BALL_SIZE  = 10,
  parameter int                 STEP       = 2,
  parameter int                 MAX_SPEED  = 7,
  parameter logic [COLOR_W-1:0] BALL_COLOR = 12'hFFF,
  parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h00F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               center,
  input  logic               mode,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  output logic [COLOR_W-1:0] color_o,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               bounce_o
);
  localparam int XMAX = H_ACTIVE - BALL_SIZE;
  localparam int YMAX = V_ACTIVE - BALL_SIZE;
  localparam logic [COORD_W-1:0]      XMAX_C   = COORD_W'(XMAX);
  localparam logic [COORD_W-1:0]      YMAX_C   = COORD_W'(YMAX);
  localparam logic [COORD_W-1:0]      X_CENTER = COORD_W'(XMAX / 2);
  localparam logic [COORD_W-1:0]      Y_CENTER = COORD_W'(YMAX / 2);
  localparam logic signed [VEL_W-1:0] V_RESET  = VEL_W'(1);
  localparam logic [COORD_W:0]        SPAN     = (COORD_W+1)'(BALL_SIZE - 1);

  state_t state, next_state;

  logic [COORD_W-1:0]      pos_x, pos_y, sh_x, sh_y;
  logic signed [VEL_W-1:0] vel_x, vel_y, sh_vx, sh_vy;
  logic                    sh_hit;

  logic [COORD_W-1:0]      ax_x, ax_y, calc_x, calc_y;
  logic signed [VEL_W-1:0] ax_vx, ax_vy, calc_vx, calc_vy;
  logic                    hit_x, hit_y, calc_hit;
  logic [COORD_W:0]        x_end, y_end;
  logic                    in_ball;

  axis_motion #(.STEP(STEP), .MAX_SPEED(MAX_SPEED)) u_axis_x (
    .pos(pos_x), .vel(vel_x), .inc(right), .dec(left), .mode(mode),
    .pos_max(XMAX_C), .next_pos(ax_x), .next_vel(ax_vx), .hit(hit_x)
  );

  axis_motion #(.STEP(STEP), .MAX_SPEED(MAX_SPEED)) u_axis_y (
    .pos(pos_y), .vel(vel_y), .inc(down), .dec(up), .mode(mode),
    .pos_max(YMAX_C), .next_pos(ax_y), .next_vel(ax_vy), .hit(hit_y)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_tick) next_state = CALC;
      CALC:    next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Centre overrides both axes; velocity is cleared only in bounce mode.
  always_comb begin
    calc_x   = ax_x;
    calc_y   = ax_y;
    calc_vx  = ax_vx;
    calc_vy  = ax_vy;
    calc_hit = hit_x | hit_y;
    if (center) begin
      calc_x   = X_CENTER;
      calc_y   = Y_CENTER;
      calc_vx  = mode ? '0 : vel_x;
      calc_vy  = mode ? '0 : vel_y;
      calc_hit = 1'b0;
    end
  end

  // NOTE: shadow registers are reset too, so an aborted update can never leak into COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x   <= X_CENTER;
      pos_y   <= Y_CENTER;
      vel_x   <= V_RESET;
      vel_y   <= V_RESET;
      sh_x    <= X_CENTER;
      sh_y    <= Y_CENTER;
      sh_vx   <= V_RESET;
      sh_vy   <= V_RESET;
      sh_hit  <= 1'b0;
      color_o <= BG_COLOR;
    end else begin
      if (state == CALC) begin
        sh_x   <= calc_x;
        sh_y   <= calc_y;
        sh_vx  <= calc_vx;
        sh_vy  <= calc_vy;
        sh_hit <= calc_hit;
      end
      if (state == COMMIT) begin
        pos_x <= sh_x;
        pos_y <= sh_y;
        vel_x <= sh_vx;
        vel_y <= sh_vy;
      end
      color_o <= in_ball ? BALL_COLOR : BG_COLOR;
    end
  end

  // The committed value is already visible during COMMIT, straight from the shadow.
  assign ball_x   = (state == COMMIT) ? sh_x : pos_x;
  assign ball_y   = (state == COMMIT) ? sh_y : pos_y;
  assign bounce_o = (state == COMMIT) && sh_hit;

  assign x_end   = {1'b0, ball_x} + SPAN;
  assign y_end   = {1'b0, ball_y} + SPAN;
  assign in_ball = (x_coord >= ball_x) && ({1'b0, x_coord} <= x_end) &&
                   (y_coord >= ball_y) && ({1'b0, y_coord} <= y_end);
endmodule

// File: tb/tb_ball_motion_renderer.sv
// Directed bench for ball_motion_renderer with default parameters (centre 315,235).
module tb_ball_motion_renderer;
  logic        clk = 1'b0;
  logic        rst, frame_tick, up, down, left, right, center, mode;
  logic [15:0] x_coord, y_coord, ball_x, ball_y;
  logic [11:0] color_o;
  logic        bounce_o;

  int n_checks = 0;
  int n_fail   = 0;

  ball_motion_renderer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .up(up), .down(down), .left(left), .right(right), .center(center),
    .mode(mode), .x_coord(x_coord), .y_coord(y_coord),
    .color_o(color_o), .ball_x(ball_x), .ball_y(ball_y), .bounce_o(bounce_o)
  );

  always #20 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  // One frame tick; records bounce_o on the CALC, COMMIT and following cycle,
  // whether the ball moved early (in CALC) and ball_x seen during COMMIT.
  task automatic tick_once(output logic [2:0] bpat, output logic early,
                           output logic [15:0] x_commit);
    logic [15:0] x0, y0;
    @(negedge clk);
    x0 = ball_x; y0 = ball_y;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    bpat[0] = bounce_o;
    early   = (ball_x !== x0) || (ball_y !== y0);
    @(negedge clk);
    bpat[1]  = bounce_o;
    x_commit = ball_x;
    @(negedge clk);
    bpat[2] = bounce_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 0; up = 0; down = 0; left = 0; right = 0;
    center = 0; mode = 0; x_coord = 16'd0; y_coord = 16'd0;
    repeat (2) @(negedge clk);
    n_checks++; if (ball_x !== 16'd315) begin n_fail++; $display("FAIL reset_ball_x: got %0d want 315", ball_x); end
    n_checks++; if (ball_y !== 16'd235) begin n_fail++; $display("FAIL reset_ball_y: got %0d want 235", ball_y); end
    n_checks++; if (color_o !== 12'h00F) begin n_fail++; $display("FAIL reset_color: got %h want 00f", color_o); end
    n_checks++; if (bounce_o !== 1'b0) begin n_fail++; $display("FAIL reset_bounce: got %b want 0", bounce_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_render();
    logic [15:0] xs [6]    = '{16'd315, 16'd324, 16'd325, 16'd314, 16'd324, 16'd320};
    logic [15:0] ys [6]    = '{16'd235, 16'd244, 16'd235, 16'd240, 16'd245, 16'd234};
    logic [11:0] exp_c [6] = '{12'hFFF, 12'hFFF, 12'h00F, 12'h00F, 12'h00F, 12'h00F};
    @(negedge clk);
    x_coord = xs[0]; y_coord = ys[0];
    #1;
    n_checks++; if (color_o !== 12'h00F) begin n_fail++; $display("FAIL render_latency: got %h want 00f before edge", color_o); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        x_coord = xs[i]; y_coord = ys[i];
      end
      @(negedge clk);
      n_checks++;
      if (color_o !== exp_c[i]) begin
        n_fail++;
        $display("FAIL render_pixel(%0d,%0d): got %h want %h", xs[i], ys[i], color_o, exp_c[i]);
      end
    end
    x_coord = 16'd0; y_coord = 16'd0;
  endtask

  task automatic test_manual();
    logic [2:0]  bpat;
    logic        early, any_bounce, any_early;
    logic [15:0] xc;
    mode = 0; right = 1;
    tick_once(bpat, early, xc);
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL manual_no_early_move: moved during CALC"); end
    n_checks++; if (xc !== 16'd317) begin n_fail++; $display("FAIL manual_commit_visible: got %0d want 317", xc); end
    any_bounce = |bpat; any_early = early;
    repeat (4) begin tick_once(bpat, early, xc); any_bounce |= |bpat; any_early |= early; end
    n_checks++; if (ball_x !== 16'd325) begin n_fail++; $display("FAIL manual_5_ticks: got %0d want 325", ball_x); end
    repeat (152) begin tick_once(bpat, early, xc); any_bounce |= |bpat; any_early |= early; end
    n_checks++; if (ball_x !== 16'd629) begin n_fail++; $display("FAIL manual_to_629: got %0d want 629", ball_x); end
    tick_once(bpat, early, xc); any_bounce |= |bpat;
    n_checks++; if (ball_x !== 16'd630) begin n_fail++; $display("FAIL manual_clamp_630: got %0d want 630", ball_x); end
    tick_once(bpat, early, xc); any_bounce |= |bpat;
    n_checks++; if (ball_x !== 16'd630) begin n_fail++; $display("FAIL manual_hold_630: got %0d want 630", ball_x); end
    n_checks++; if (ball_y !== 16'd235) begin n_fail++; $display("FAIL manual_y_static: got %0d want 235", ball_y); end
    n_checks++; if (any_bounce !== 1'b0) begin n_fail++; $display("FAIL manual_no_bounce: bounce_o seen high"); end
    n_checks++; if (any_early !== 1'b0) begin n_fail++; $display("FAIL manual_timing: ball moved during CALC"); end
    right = 0;
  endtask

  task automatic test_opposing();
    logic [2:0]  bpat;
    logic        early;
    logic [15:0] xc;
    left = 1; right = 1; up = 1; down = 1;
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd630 || ball_y !== 16'd235) begin n_fail++; $display("FAIL opposing_hold: got (%0d,%0d) want (630,235)", ball_x, ball_y); end
    left = 0; right = 0; down = 0;
    tick_once(bpat, early, xc);
    n_checks++; if (ball_y !== 16'd233) begin n_fail++; $display("FAIL manual_up: got %0d want 233", ball_y); end
    up = 0; down = 1;
    tick_once(bpat, early, xc);
    n_checks++; if (ball_y !== 16'd235) begin n_fail++; $display("FAIL manual_down: got %0d want 235", ball_y); end
    down = 0;
  endtask

  task automatic test_bounce();
    logic [2:0]  bpat;
    logic        early;
    logic [15:0] xc;
    mode = 1; center = 1;
    tick_once(bpat, early, xc);
    center = 0;
    n_checks++; if (ball_x !== 16'd315 || ball_y !== 16'd235) begin n_fail++; $display("FAIL bounce_center: got (%0d,%0d) want (315,235)", ball_x, ball_y); end
    right = 1;
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd316) begin n_fail++; $display("FAIL accel_v1: got %0d want 316", ball_x); end
    tick_once(bpat, early, xc);
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd321) begin n_fail++; $display("FAIL accel_v3: got %0d want 321", ball_x); end
    mode = 0;
    repeat (155) tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd630) begin n_fail++; $display("FAIL setup_630: got %0d want 630", ball_x); end
    right = 0; left = 1;
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd628) begin n_fail++; $display("FAIL manual_left: got %0d want 628", ball_x); end
    left = 0; mode = 1;
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd630) begin n_fail++; $display("FAIL bounce_wall_pos: got %0d want 630", ball_x); end
    n_checks++; if (bpat !== 3'b010) begin n_fail++; $display("FAIL bounce_pulse: got %b want 010", bpat); end
    n_checks++; if (ball_y !== 16'd235) begin n_fail++; $display("FAIL bounce_y_static: got %0d want 235", ball_y); end
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd627) begin n_fail++; $display("FAIL bounce_reversed_v: got %0d want 627", ball_x); end
    n_checks++; if (bpat !== 3'b000) begin n_fail++; $display("FAIL bounce_no_repeat: got %b want 000", bpat); end
  endtask

  task automatic test_saturation();
    logic [2:0]  bpat;
    logic        early;
    logic [15:0] xc;
    mode = 1; center = 1;
    tick_once(bpat, early, xc);
    center = 0; right = 1;
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd316) begin n_fail++; $display("FAIL sat_start: got %0d want 316", ball_x); end
    repeat (10) tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd371) begin n_fail++; $display("FAIL sat_10_ticks: got %0d want 371", ball_x); end
    right = 0;
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd378) begin n_fail++; $display("FAIL sat_v7: got %0d want 378", ball_x); end
    center = 1;
    tick_once(bpat, early, xc);
    center = 0;
    n_checks++; if (ball_x !== 16'd315 || ball_y !== 16'd235) begin n_fail++; $display("FAIL sat_center: got (%0d,%0d) want (315,235)", ball_x, ball_y); end
    n_checks++; if (bpat !== 3'b000) begin n_fail++; $display("FAIL center_no_bounce: got %b want 000", bpat); end
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd315 || ball_y !== 16'd235) begin n_fail++; $display("FAIL center_v_zero: got (%0d,%0d) want (315,235)", ball_x, ball_y); end
  endtask

  task automatic test_mid_reset();
    logic [2:0]  bpat;
    logic        early;
    logic [15:0] xc;
    mode = 0; right = 1;
    tick_once(bpat, early, xc);
    n_checks++; if (ball_x !== 16'd317) begin n_fail++; $display("FAIL pre_reset_move: got %0d want 317", ball_x); end
    @(negedge clk); frame_tick = 1;
    @(negedge clk); frame_tick = 0; rst = 1;
    #1;
    n_checks++; if (ball_x !== 16'd315 || ball_y !== 16'd235) begin n_fail++; $display("FAIL mid_reset_abort: got (%0d,%0d) want (315,235)", ball_x, ball_y); end
    @(negedge clk); rst = 0;
    n_checks++; if (bounce_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bounce: got %b want 0", bounce_o); end
    repeat (3) @(negedge clk);
    n_checks++; if (ball_x !== 16'd315) begin n_fail++; $display("FAIL mid_reset_no_commit: got %0d want 315", ball_x); end
    @(negedge clk); frame_tick = 1;
    @(negedge clk);
    @(negedge clk); frame_tick = 0;
    n_checks++; if (ball_x !== 16'd317) begin n_fail++; $display("FAIL dropped_tick_commit: got %0d want 317", ball_x); end
    repeat (5) @(negedge clk);
    n_checks++; if (ball_x !== 16'd317) begin n_fail++; $display("FAIL dropped_tick_once: got %0d want 317", ball_x); end
    right = 0;
  endtask

  initial begin
    test_reset();
    test_render();
    test_manual();
    test_opposing();
    test_bounce();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
